// File: rtl/fp_add_arbiter_if.sv
// Bundles the requester, shared-adder and response buses of fp_add_arbiter.
// slave = arbiter side, master = environment (requesters, adder, consumer).
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_opx;
    logic [32*NUM_REQ-1:0] req_opy;
    logic [31:0]           add_x;
    logic [31:0]           add_y;
    logic [31:0]           add_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_nan;
    logic                  busy;

    modport slave (
        input  req_valid, req_opx, req_opy, add_result, rsp_ready,
        output req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_data, rsp_nan, busy
    );

    modport master (
        output req_valid, req_opx, req_opy, add_result, rsp_ready,
        input  req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_data, rsp_nan, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp adder among NUM_REQ requesters.
// Latency: 2 edges accept-to-rsp_valid; one operation per 3 cycles at best.
// Backpressure: response held in RESP until rsp_ready; no grants while busy.
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    fp_add_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
    } opnd_t;

    state_e             state_q, state_d;
    opnd_t              opnd_q, opnd_d, sel_opnd;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [31:0]        data_q, data_d;
    logic               nan_q, nan_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    rr_idx;
    logic               win_found;

    // Search begins one past the last granted index and wraps.
    always_comb begin
        win_oh    = '0;
        win_id    = '0;
        win_found = 1'b0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (int'(last_q) + k >= NUM_REQ) begin
                rr_idx = ID_W'(int'(last_q) + k - NUM_REQ);
            end else begin
                rr_idx = ID_W'(int'(last_q) + k);
            end
            if (!win_found && bus.req_valid[rr_idx]) begin
                win_found      = 1'b1;
                win_oh[rr_idx] = 1'b1;
                win_id         = rr_idx;
            end
        end
    end

    always_comb begin
        sel_opnd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_opnd.x = bus.req_opx[32*i +: 32];
                sel_opnd.y = bus.req_opy[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        id_d    = id_q;
        last_d  = last_q;
        data_d  = data_q;
        nan_d   = nan_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    opnd_d  = sel_opnd;
                    id_d    = win_id;
                    last_d  = win_id;
                end
            end
            ISSUE: begin
                state_d = RESP;
                data_d  = bus.add_result;
                nan_d   = (&bus.add_result[30:23]) && (|bus.add_result[22:0]);
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            id_q        <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            data_q      <= '0;
            nan_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            id_q        <= id_d;
            last_q      <= last_d;
            data_q      <= data_d;
            nan_q       <= nan_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Grant is masked by rst so it drops the moment reset is raised.
    assign bus.req_ready = (state_q == IDLE && !rst) ? win_oh : '0;
    assign bus.add_x     = opnd_q.x;
    assign bus.add_y     = opnd_q.y;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_nan   = nan_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin and fp-sum reference model.
module tb_fp_add_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   model_last;

    always #5 clk = ~clk;

    fp_add_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus();

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic real f32_to_real(logic [31:0] f);
        logic [63:0] b;
        int          e;
        if (f[30:23] == 8'h00) return 0.0;
        e = int'(f[30:23]) + 896;
        b = {f[31], e[10:0], f[22:0], 29'b0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] real_to_f32(real r);
        logic [63:0] b;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return 32'h0;
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Stand-in for the shared adder; operands used here are exactly representable sums.
    function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
        logic an, bn, ai, bi;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (an || bn) return 32'h7FC00000;
        if (ai && bi) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (ai) return a;
        if (bi) return b;
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    always_comb bus.add_result = fp_add(bus.add_x, bus.add_y);

    function automatic int rr_pick(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (((v >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_f32();
        int n;
        if ($urandom_range(0, 15) == 0) return 32'h7FC00001;
        n = int'($urandom_range(0, 4000)) - 2000;
        return real_to_f32(real'(n));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int i, logic [31:0] x, logic [31:0] y);
        bus.req_opx[32*i +: 32] = x;
        bus.req_opy[32*i +: 32] = y;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_opx   = '0;
        bus.req_opy   = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset rsp_data got=%h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_nan !== 1'b0) begin errors++; $display("FAIL reset rsp_nan got=%b exp=0", bus.rsp_nan); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        checks++; if (bus.add_x !== 32'h0) begin errors++; $display("FAIL reset add_x got=%h exp=0", bus.add_x); end
        checks++; if (bus.add_y !== 32'h0) begin errors++; $display("FAIL reset add_y got=%h exp=0", bus.add_y); end
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 32'h3F800000, 32'h3F800000);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single grant got=%b exp=0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single issue busy got=%b exp=1", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single issue rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.add_x !== 32'h3F800000) begin errors++; $display("FAIL single add_x got=%h exp=3f800000", bus.add_x); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single rsp_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'h40000000) begin errors++; $display("FAIL single rsp_data got=%h exp=40000000", bus.rsp_data); end
        checks++; if (bus.rsp_nan !== 1'b0) begin errors++; $display("FAIL single rsp_nan got=%b exp=0", bus.rsp_nan); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single done busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'h40000000, 32'h40400000);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 5; t++) begin
            exp_oh = N'(1) << (t % N);
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rr grant%0d got=%b exp=%b", t, bus.req_ready, exp_oh); end
            step();
            step();
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr rsp_valid%0d got=%b exp=1", t, bus.rsp_valid); end
            checks++; if (int'(bus.rsp_id) !== t % N) begin errors++; $display("FAIL rr rsp_id%0d got=%0d exp=%0d", t, bus.rsp_id, t % N); end
            checks++; if (bus.rsp_data !== 32'h40A00000) begin errors++; $display("FAIL rr rsp_data%0d got=%h exp=40a00000", t, bus.rsp_data); end
            step();
            if (t == 4) bus.req_valid = '0;
            #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 32'h40000000, 32'h40400000);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp rsp_valid c%0d got=%b exp=1", c, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 32'h40A00000) begin errors++; $display("FAIL bp rsp_data c%0d got=%h exp=40a00000", c, bus.rsp_data); end
            checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL bp rsp_id c%0d got=%0d exp=0", c, bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp req_ready c%0d got=%b exp=0000", c, bus.req_ready); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp busy c%0d got=%b exp=1", c, bus.busy); end
            set_op(0, $urandom, $urandom);
            #1;
            checks++; if (bus.add_x !== 32'h40000000) begin errors++; $display("FAIL bp add_x c%0d got=%h exp=40000000", c, bus.add_x); end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp release busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp release rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp release grant got=%b exp=0010", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_nan();
        do_reset();
        set_op(2, 32'hFF800000, 32'h7F800000);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL nan grant got=%b exp=0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL nan rsp_id got=%0d exp=2", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'h7FC00000) begin errors++; $display("FAIL nan rsp_data got=%h exp=7fc00000", bus.rsp_data); end
        checks++; if (bus.rsp_nan !== 1'b1) begin errors++; $display("FAIL nan rsp_nan got=%b exp=1", bus.rsp_nan); end
        step();
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        set_op(3, 32'h40000000, 32'h40000000);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        step();
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rmr precond rsp_valid got=%b exp=1", bus.rsp_valid); end
        bus.req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmr rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmr busy got=%b exp=0", bus.busy); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rmr req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.add_x !== 32'h0) begin errors++; $display("FAIL rmr add_x got=%h exp=0", bus.add_x); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rmr rsp_data got=%h exp=0", bus.rsp_data); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        set_op(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmr first grant got=%b exp=0001", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmr stale rsp_valid got=%b exp=0", bus.rsp_valid); end
        step();
        bus.req_valid = '0;
        step();
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rmr rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'h40400000) begin errors++; $display("FAIL rmr rsp_data got=%h exp=40400000", bus.rsp_data); end
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        set_op(3, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h40000000, 32'h3F800000);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap first grant got=%b exp=1000", bus.req_ready); end
        step();
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wrap issue req_ready got=%b exp=0000", bus.req_ready); end
        step();
        checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL wrap rsp_id got=%0d exp=3", bus.rsp_id); end
        step();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap next grant got=%b exp=0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL wrap rsp_id2 got=%0d exp=1", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'h40400000) begin errors++; $display("FAIL wrap rsp_data got=%h exp=40400000", bus.rsp_data); end
        step();
    endtask

    task automatic test_random();
        logic [N-1:0]  v;
        logic [N-1:0]  exp_oh;
        logic [31:0]   ex, ey, exp_sum;
        logic          exp_nan;
        int            win, hold, gap;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.req_valid = '0;
                #1;
                checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rnd idle t%0d req_ready=%b busy=%b exp 0000/0", t, bus.req_ready, bus.busy); end
                step();
            end
            for (int i = 0; i < N; i++) set_op(i, rnd_f32(), rnd_f32());
            v = N'($urandom_range(1, 15));
            bus.req_valid = v;
            bus.rsp_ready = 1'b0;
            #1;
            win    = rr_pick(model_last, v);
            exp_oh = N'(1) << win;
            ex     = bus.req_opx[32*win +: 32];
            ey     = bus.req_opy[32*win +: 32];
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rnd grant t%0d got=%b exp=%b", t, bus.req_ready, exp_oh); end
            step();
            model_last = win;
            bus.req_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) set_op(i, rnd_f32(), rnd_f32());
            #1;
            checks++; if (bus.add_x !== ex || bus.add_y !== ey) begin errors++; $display("FAIL rnd operands t%0d got=%h,%h exp=%h,%h", t, bus.add_x, bus.add_y, ex, ey); end
            checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL rnd issue t%0d req_ready=%b busy=%b exp 0000/1", t, bus.req_ready, bus.busy); end
            step();
            exp_sum = fp_add(ex, ey);
            exp_nan = (exp_sum[30:23] == 8'hFF) && (exp_sum[22:0] != 23'd0);
            hold    = int'($urandom_range(0, 3));
            for (int h = 0; h <= hold; h++) begin
                checks++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) !== win) begin errors++; $display("FAIL rnd rsp t%0d h%0d valid=%b id=%0d exp 1/%0d", t, h, bus.rsp_valid, bus.rsp_id, win); end
                checks++; if (bus.rsp_data !== exp_sum || bus.rsp_nan !== exp_nan) begin errors++; $display("FAIL rnd data t%0d h%0d got=%h nan=%b exp=%h nan=%b", t, h, bus.rsp_data, bus.rsp_nan, exp_sum, exp_nan); end
                bus.req_valid = N'($urandom_range(0, 15));
                if (h == hold) bus.rsp_ready = 1'b1;
                step();
            end
            bus.req_valid = '0;
            bus.rsp_ready = 1'b0;
            #1;
            checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rnd done t%0d valid=%b busy=%b exp 0/0", t, bus.rsp_valid, bus.busy); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_nan();
        test_reset_mid_resp();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one combinational fp_adder (legal range 2..8).
REQ-002 Parameter ID_W, default 2, width of requester index, SHALL equal ceil(log2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_opx  input  32*NUM_REQ  IEEE754 single operand X; requester i occupies bits [32i+31:32i].
REQ-007 req_opy  input  32*NUM_REQ  IEEE754 single operand Y; same packing as req_opx.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; request i accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 add_x  output  32  operand X to the shared fp_adder (operandX).
REQ-010 add_y  output  32  operand Y to the shared fp_adder (operandY).
REQ-011 add_result  input  32  sum from the shared fp_adder (result), combinational from add_x/add_y.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_id  output  ID_W  index of requester owning the response.
REQ-014 rsp_data  output  32  registered sum.
REQ-015 rsp_nan  output  1  high when rsp_data exponent is all ones and mantissa nonzero.
REQ-016 rsp_ready  input  1  consumer accepts response when rsp_valid and rsp_ready are high at an edge.
REQ-017 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP; encoding implementation-defined.
REQ-019 IDLE: req_ready SHALL be one-hot on the round-robin winner among asserted req_valid bits, zero if none valid; on acceptance, capture opx/opy of winner into operand registers, winner index into id register, go to ISSUE.
REQ-020 Round-robin: search starts at index (last_grant+1) mod NUM_REQ, wrapping; last_grant updates only on acceptance.
REQ-021 req_ready SHALL be all-zero in ISSUE and RESP.
REQ-022 add_x/add_y SHALL be driven from the operand registers at all times (never directly from req_opx/req_opy).
REQ-023 ISSUE: register add_result into rsp_data, compute rsp_nan from it, go to RESP; exactly one cycle.
REQ-024 RESP: rsp_valid high; rsp_data, rsp_id, rsp_nan held stable until handshake; on rsp_ready go to IDLE.
REQ-025 Minimum accept-to-rsp_valid latency SHALL be 2 clock edges; minimum throughput one operation per 3 cycles.
REQ-026 A requester deasserting req_valid before grant SHALL lose no state; a later request is arbitrated normally.
REQ-027 Back-to-back: in the IDLE cycle following a RESP handshake, a new grant SHALL be possible (no extra idle cycle).
REQ-028 Arbiter SHALL not inspect operand values; NaN/Inf/zero/subnormal handling is entirely the adder's.

Reset
REQ-029 On rst assertion, at any time including mid-ISSUE or mid-RESP: FSM to IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_nan=0, busy=0, operand registers=0 (add_x=add_y=0), last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-030 An in-flight operation interrupted by reset SHALL be discarded without a response.

Verification
REQ-031 Single request: req0 valid, opx=3F800000, opy=3F800000, rsp_ready=1 -> req_ready=0001 in first cycle, rsp_valid 2 edges later with rsp_id=0, rsp_data=40000000, rsp_nan=0.
REQ-032 All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; each response id matches its grant; requester i sums 40000000+40400000 -> 40A00000.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready all-zero, busy=1; release -> IDLE next edge.
REQ-034 NaN: req2 opx=FF800000, opy=7F800000 -> rsp_id=2, rsp_data=7FC00000, rsp_nan=1.
REQ-035 Reset mid-RESP: assert rst asynchronously between edges -> rsp_valid, busy, req_ready fall immediately; after release, req0 wins first grant even if req3 also valid.
REQ-036 Wrap: last grant 3, req1 and req3 valid -> req1 granted next.
